ps_seizure_detector: RTL and testbench

Downstream consumer of the power-feature stage (ps_module). It takes the 40-bit signed band-power value and its data_valid strobe, and tracks an exponential-moving-average baseline of that feature. It applies hysteresis thresholds with consecutive-window debouncing and outputs a registered seizure flag, onset/offset pulses and an event counter for the top-level classifier and logging path.

---
 rtl/ps_det_pkg.sv | 17 +
 rtl/ps_seizure_detector_if.sv | 32 +++
 rtl/ps_ema_baseline.sv | 52 +++++
 rtl/ps_seizure_detector.sv | 145 ++++++++++++++
 tb/tb_ps_seizure_detector.sv | 206 ++++++++++++++++++++
 5 files changed

// File: rtl/ps_det_pkg.sv
// rtl/ps_det_pkg.sv - shared types and default widths for the seizure detector
// Contents: detector FSM state enum, default feature/counter widths.
package ps_det_pkg;

    // Same as the power-feature stage output width.
    localparam int DEF_FEAT_WIDTH = 40;
    localparam int DEF_CNT_WIDTH  = 16;

    typedef enum logic [2:0] {
        WARMUP,
        NORMAL,
        PENDING_ON,
        SEIZURE,
        PENDING_OFF
    } det_state_e;

endpackage

// File: rtl/ps_seizure_detector_if.sv
// rtl/ps_seizure_detector_if.sv - feature-in / detection-out bundle
// Inputs : en, din_valid, din, thr_on, thr_off (driven by master)
// Outputs: seizure, onset, offset, event_count, baseline (driven by slave)
interface ps_seizure_detector_if
    import ps_det_pkg::*;
#(
    parameter int FEAT_WIDTH = DEF_FEAT_WIDTH,
    parameter int CNT_WIDTH  = DEF_CNT_WIDTH
) ();

    logic                         en;
    logic                         din_valid;
    logic signed [FEAT_WIDTH-1:0] din;
    logic        [FEAT_WIDTH-1:0] thr_on;
    logic        [FEAT_WIDTH-1:0] thr_off;
    logic                         seizure;
    logic                         onset;
    logic                         offset;
    logic        [CNT_WIDTH-1:0]  event_count;
    logic signed [FEAT_WIDTH-1:0] baseline;

    modport master (
        output en, din_valid, din, thr_on, thr_off,
        input  seizure, onset, offset, event_count, baseline
    );

    modport slave (
        input  en, din_valid, din, thr_on, thr_off,
        output seizure, onset, offset, event_count, baseline
    );

endinterface

// File: rtl/ps_ema_baseline.sv
// rtl/ps_ema_baseline.sv - exponential moving average baseline register
// clk, rst     : clock, synchronous active-high reset
// load_i       : load din_i directly into the baseline
// update_i     : baseline += (din_i - baseline) >>> ALPHA_SHIFT
// din_i        : signed feature sample
// diff_o       : din_i - baseline, one bit wider than the feature
// baseline_o   : current baseline
module ps_ema_baseline
    import ps_det_pkg::*;
#(
    parameter int FEAT_WIDTH  = DEF_FEAT_WIDTH,
    parameter int ALPHA_SHIFT = 4
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         load_i,
    input  logic                         update_i,
    input  logic signed [FEAT_WIDTH-1:0] din_i,
    output logic signed [FEAT_WIDTH:0]   diff_o,
    output logic signed [FEAT_WIDTH-1:0] baseline_o
);

    logic signed [FEAT_WIDTH-1:0] base_q, base_d;
    logic signed [FEAT_WIDTH:0]   din_x, base_x, step, sum;

    always_comb begin
        din_x  = $signed({din_i[FEAT_WIDTH-1], din_i});
        base_x = $signed({base_q[FEAT_WIDTH-1], base_q});
        diff_o = din_x - base_x;
        step   = diff_o >>> ALPHA_SHIFT;
        // The moved baseline always lies between old baseline and din,
        // so dropping the extra bit cannot lose information.
        sum    = base_x + step;
        base_d = base_q;
        if (load_i) begin
            base_d = din_i;
        end else if (update_i) begin
            base_d = sum[FEAT_WIDTH-1:0];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            base_q <= '0;
        end else begin
            base_q <= base_d;
        end
    end

    assign baseline_o = base_q;

endmodule

// File: rtl/ps_seizure_detector.sv
// rtl/ps_seizure_detector.sv - hysteresis/debounce seizure detector on band power
// clk, rst : clock, synchronous active-high reset
// bus      : slave side of ps_seizure_detector_if (feature in, flags/counters out)
module ps_seizure_detector
    import ps_det_pkg::*;
#(
    parameter int FEAT_WIDTH  = DEF_FEAT_WIDTH,
    parameter int ALPHA_SHIFT = 4,
    parameter int WARMUP_N    = 16,
    parameter int ON_COUNT    = 4,
    parameter int OFF_COUNT   = 8,
    parameter int CNT_WIDTH   = DEF_CNT_WIDTH
) (
    input logic                  clk,
    input logic                  rst,
    ps_seizure_detector_if.slave bus
);

    localparam int WU_W  = $clog2(WARMUP_N + 1);
    localparam int ON_W  = $clog2(ON_COUNT + 1);
    localparam int OFF_W = $clog2(OFF_COUNT + 1);

    det_state_e           state_q;
    logic [WU_W-1:0]      warm_cnt_q;
    logic [ON_W-1:0]      on_cnt_q;
    logic [OFF_W-1:0]     off_cnt_q;
    logic                 seizure_q, onset_q, offset_q;
    logic [CNT_WIDTH-1:0] event_cnt_q, event_cnt_d;

    logic                         accept, above, below, ema_load, ema_update;
    logic signed [FEAT_WIDTH:0]   diff, thr_on_x, thr_off_x;
    logic signed [FEAT_WIDTH-1:0] baseline;

    ps_ema_baseline #(
        .FEAT_WIDTH (FEAT_WIDTH),
        .ALPHA_SHIFT(ALPHA_SHIFT)
    ) u_ema (
        .clk       (clk),
        .rst       (rst),
        .load_i    (ema_load),
        .update_i  (ema_update),
        .din_i     (bus.din),
        .diff_o    (diff),
        .baseline_o(baseline)
    );

    always_comb begin
        accept    = bus.en & bus.din_valid;
        // Margins are unsigned; widen with a zero so the compare stays signed.
        thr_on_x  = $signed({1'b0, bus.thr_on});
        thr_off_x = $signed({1'b0, bus.thr_off});
        above     = diff > thr_on_x;
        below     = diff < thr_off_x;
        ema_load  = accept && (state_q == WARMUP) && (warm_cnt_q == '0);
        // Baseline tracks only outside a (pending) seizure and only on
        // samples that do not look like one.
        ema_update = accept && (((state_q == WARMUP) && (warm_cnt_q != '0)) ||
                                (((state_q == NORMAL) || (state_q == PENDING_ON)) && !above));
        event_cnt_d = (event_cnt_q == '1) ? event_cnt_q : event_cnt_q + CNT_WIDTH'(1);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= WARMUP;
            warm_cnt_q  <= '0;
            on_cnt_q    <= '0;
            off_cnt_q   <= '0;
            seizure_q   <= 1'b0;
            onset_q     <= 1'b0;
            offset_q    <= 1'b0;
            event_cnt_q <= '0;
        end else begin
            onset_q  <= 1'b0;
            offset_q <= 1'b0;
            if (accept) begin
                case (state_q)
                    WARMUP: begin
                        warm_cnt_q <= warm_cnt_q + WU_W'(1);
                        if (warm_cnt_q == WU_W'(WARMUP_N - 1)) state_q <= NORMAL;
                    end
                    NORMAL: begin
                        if (above) begin
                            if (ON_COUNT == 1) begin
                                state_q     <= SEIZURE;
                                seizure_q   <= 1'b1;
                                onset_q     <= 1'b1;
                                event_cnt_q <= event_cnt_d;
                            end else begin
                                on_cnt_q <= ON_W'(1);
                                state_q  <= PENDING_ON;
                            end
                        end
                    end
                    PENDING_ON: begin
                        if (!above) begin
                            on_cnt_q <= '0;
                            state_q  <= NORMAL;
                        end else if (on_cnt_q == ON_W'(ON_COUNT - 1)) begin
                            on_cnt_q    <= '0;
                            state_q     <= SEIZURE;
                            seizure_q   <= 1'b1;
                            onset_q     <= 1'b1;
                            event_cnt_q <= event_cnt_d;
                        end else begin
                            on_cnt_q <= on_cnt_q + ON_W'(1);
                        end
                    end
                    SEIZURE: begin
                        if (below) begin
                            if (OFF_COUNT == 1) begin
                                state_q   <= NORMAL;
                                seizure_q <= 1'b0;
                                offset_q  <= 1'b1;
                            end else begin
                                off_cnt_q <= OFF_W'(1);
                                state_q   <= PENDING_OFF;
                            end
                        end
                    end
                    PENDING_OFF: begin
                        if (!below) begin
                            off_cnt_q <= '0;
                            state_q   <= SEIZURE;
                        end else if (off_cnt_q == OFF_W'(OFF_COUNT - 1)) begin
                            off_cnt_q <= '0;
                            state_q   <= NORMAL;
                            seizure_q <= 1'b0;
                            offset_q  <= 1'b1;
                        end else begin
                            off_cnt_q <= off_cnt_q + OFF_W'(1);
                        end
                    end
                    default: state_q <= WARMUP;
                endcase
            end
        end
    end

    assign bus.seizure     = seizure_q;
    assign bus.onset       = onset_q;
    assign bus.offset      = offset_q;
    assign bus.event_count = event_cnt_q;
    assign bus.baseline    = baseline;

endmodule

// File: tb/tb_ps_seizure_detector.sv
// tb/tb_ps_seizure_detector.sv - self-checking bench for ps_seizure_detector
module tb_ps_seizure_detector;

    localparam int FW = 40;

    typedef struct {
        logic                 rst, en, vld;
        logic signed [FW-1:0] din;
        logic [FW-1:0]        ton, toff;
        logic                 seiz, on, off;
        int                   ec;
        longint               base;
    } vec_t;

    logic                 clk = 1'b0;
    logic                 rst = 1'b1;
    logic                 en = 1'b0;
    logic                 vld = 1'b0;
    logic signed [FW-1:0] din = '0;
    logic [FW-1:0]        thr_on = 40'd500;
    logic [FW-1:0]        thr_off = 40'd200;

    int tests = 0;
    int fails = 0;
    vec_t vecs[$];

    always #5 clk = ~clk;

    ps_seizure_detector_if #(.FEAT_WIDTH(FW), .CNT_WIDTH(16)) u_if ();
    ps_seizure_detector_if #(.FEAT_WIDTH(FW), .CNT_WIDTH(2))  u_if2 ();

    assign u_if.en = en;         assign u_if2.en = en;
    assign u_if.din_valid = vld; assign u_if2.din_valid = vld;
    assign u_if.din = din;       assign u_if2.din = din;
    assign u_if.thr_on = thr_on; assign u_if2.thr_on = thr_on;
    assign u_if.thr_off = thr_off; assign u_if2.thr_off = thr_off;

    ps_seizure_detector #(.CNT_WIDTH(16)) u_dut  (.clk(clk), .rst(rst), .bus(u_if));
    ps_seizure_detector #(.CNT_WIDTH(2))  u_dut2 (.clk(clk), .rst(rst), .bus(u_if2));

    // Reference: warm-up count, seizure flag and a run length of
    // consecutive qualifying samples; baseline in plain 64-bit arithmetic.
    int     m_warm = 0, m_streak = 0, m_ec = 0;
    bit     m_seiz = 0, m_on = 0, m_off = 0;
    longint m_base = 0;

    always @(posedge clk) begin
        longint d, diff;
        bit ab, bl;
        if (rst) begin
            m_warm = 0; m_streak = 0; m_ec = 0;
            m_seiz = 0; m_on = 0; m_off = 0; m_base = 0;
        end else begin
            m_on = 0; m_off = 0;
            if (en && vld) begin
                d    = longint'(din);
                diff = d - m_base;
                ab   = diff > longint'(thr_on);
                bl   = diff < longint'(thr_off);
                if (m_warm < 16) begin
                    m_base = (m_warm == 0) ? d : m_base + (diff >>> 4);
                    m_warm++;
                end else if (!m_seiz) begin
                    if (ab) begin
                        m_streak++;
                        if (m_streak == 4) begin
                            m_seiz = 1; m_on = 1; m_streak = 0;
                            if (m_ec < 65535) m_ec++;
                        end
                    end else begin
                        m_streak = 0;
                        m_base = m_base + (diff >>> 4);
                    end
                end else begin
                    if (bl) begin
                        m_streak++;
                        if (m_streak == 8) begin
                            m_seiz = 0; m_off = 1; m_streak = 0;
                        end
                    end else begin
                        m_streak = 0;
                    end
                end
            end
        end
    end

    task automatic check(input string name, input longint act, input longint exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic drive(input logic r, input logic e, input logic v,
                         input logic signed [FW-1:0] d, input logic [FW-1:0] ton,
                         input logic [FW-1:0] toff);
        rst = r; en = e; vld = v; din = d; thr_on = ton; thr_off = toff;
        @(posedge clk);
        #1;
    endtask

    task automatic add(input logic r, input logic e, input logic v, input longint d,
                       input longint ton, input logic seiz, input logic on,
                       input logic off, input int ec, input longint base);
        vec_t x;
        x.rst = r; x.en = e; x.vld = v; x.din = d[FW-1:0];
        x.ton = ton[FW-1:0]; x.toff = 40'd200;
        x.seiz = seiz; x.on = on; x.off = off; x.ec = ec; x.base = base;
        vecs.push_back(x);
    endtask

    function automatic int sat3(input int v);
        return (v > 3) ? 3 : v;
    endfunction

    initial begin
        // ---------------- directed table ----------------
        for (int i = 0; i < 10; i++) add(1, 0, 0, 0, 500, 0, 0, 0, 0, 0);
        for (int i = 0; i < 16; i++) add(0, 1, 1, 1000, 500, 0, 0, 0, 0, 1000);
        add(0, 1, 1, 1000, 0, 0, 0, 0, 0, 1000);              // diff == thr_on
        for (int i = 0; i < 3; i++) add(0, 1, 1, 2000, 500, 0, 0, 0, 0, 1000);
        add(0, 1, 1, 1000, 500, 0, 0, 0, 0, 1000);
        for (int i = 0; i < 3; i++) add(0, 1, 1, 2000, 500, 0, 0, 0, 0, 1000);
        add(0, 0, 1, 2000, 500, 0, 0, 0, 0, 1000);            // en=0 in PENDING_ON
        add(0, 0, 1, 2000, 500, 0, 0, 0, 0, 1000);
        add(0, 1, 0, 2000, 500, 0, 0, 0, 0, 1000);
        add(0, 1, 1, 2000, 500, 1, 1, 0, 1, 1000);            // onset
        add(0, 0, 1, 1100, 500, 1, 0, 0, 1, 1000);            // pulse drops with en=0
        add(0, 1, 1, 1200, 500, 1, 0, 0, 1, 1000);            // diff == thr_off
        for (int i = 0; i < 7; i++) add(0, 1, 1, 1100, 500, 1, 0, 0, 1, 1000);
        add(0, 1, 1, 1500, 500, 1, 0, 0, 1, 1000);
        for (int i = 0; i < 7; i++) add(0, 1, 1, 1100, 500, 1, 0, 0, 1, 1000);
        add(0, 1, 1, 1100, 500, 0, 0, 1, 1, 1000);            // offset
        add(0, 1, 0, 1100, 500, 0, 0, 0, 1, 1000);
        add(0, 1, 1, 1100, 500, 0, 0, 0, 1, 1006);            // EMA resumes
        for (int i = 0; i < 3; i++) add(0, 1, 1, 2000, 500, 0, 0, 0, 1, 1006);
        add(0, 1, 1, 2000, 500, 1, 1, 0, 2, 1006);
        add(1, 1, 1, 2000, 500, 0, 0, 0, 0, 0);               // reset mid-seizure
        add(0, 1, 0, 2000, 500, 0, 0, 0, 0, 0);
        add(0, 1, 1, 500, 500, 0, 0, 0, 0, 500);              // warm-up load again

        foreach (vecs[i]) begin
            drive(vecs[i].rst, vecs[i].en, vecs[i].vld, vecs[i].din, vecs[i].ton, vecs[i].toff);
            check($sformatf("vec%0d.seizure", i), u_if.seizure, vecs[i].seiz);
            check($sformatf("vec%0d.onset", i), u_if.onset, vecs[i].on);
            check($sformatf("vec%0d.offset", i), u_if.offset, vecs[i].off);
            check($sformatf("vec%0d.event_count", i), u_if.event_count, vecs[i].ec);
            check($sformatf("vec%0d.baseline", i), u_if.baseline, vecs[i].base);
            check($sformatf("vec%0d.event_count_w2", i), u_if2.event_count, sat3(vecs[i].ec));
        end

        // ---------------- saturation with CNT_WIDTH=2 ----------------
        drive(1, 0, 0, 0, 500, 200);
        drive(1, 0, 0, 0, 500, 200);
        for (int i = 0; i < 16; i++) drive(0, 1, 1, 1000, 500, 200);
        for (int k = 1; k <= 5; k++) begin
            for (int i = 0; i < 4; i++) drive(0, 1, 1, 2000, 500, 200);
            check($sformatf("sat%0d.onset", k), u_if.onset, 1);
            check($sformatf("sat%0d.event_count", k), u_if.event_count, k);
            check($sformatf("sat%0d.event_count_w2", k), u_if2.event_count, sat3(k));
            for (int i = 0; i < 8; i++) drive(0, 1, 1, 1100, 500, 200);
            check($sformatf("sat%0d.offset", k), u_if.offset, 1);
            check($sformatf("sat%0d.seizure", k), u_if2.seizure, 0);
        end

        // ---------------- randomized against reference ----------------
        drive(1, 0, 0, 0, 500, 200);
        begin
            int mode = 0;
            for (int n = 0; n < 4000; n++) begin
                longint dv;
                logic [FW-1:0] ton, toff;
                logic r, e, v;
                if (n % 16 == 0) mode = $urandom_range(0, 2);
                ton  = 40'($urandom_range(250, 550));
                toff = 40'($urandom_range(100, 300));
                if (m_warm < 16)
                    dv = longint'($urandom_range(0, 400)) - 200;
                else if ($urandom_range(0, 15) == 0)
                    dv = m_base + longint'(ton);
                else if (mode == 0)
                    dv = m_base + 300 + longint'($urandom_range(0, 900));
                else if (mode == 1)
                    dv = m_base - 300 + longint'($urandom_range(0, 500));
                else
                    dv = m_base - 300 + longint'($urandom_range(0, 1500));
                r = ($urandom_range(0, 999) == 0);
                e = ($urandom_range(0, 9) != 0);
                v = ($urandom_range(0, 9) < 7);
                drive(r, e, v, dv[FW-1:0], ton, toff);
                check("rand.seizure", u_if.seizure, m_seiz);
                check("rand.onset", u_if.onset, m_on);
                check("rand.offset", u_if.offset, m_off);
                check("rand.event_count", u_if.event_count, m_ec);
                check("rand.baseline", u_if.baseline, m_base);
                check("rand.event_count_w2", u_if2.event_count, sat3(m_ec));
            end
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
